// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the ram8156 two-port arbiter.
// Holds the FSM state enum and the latched-request record.
package ram_arb_pkg;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int DW   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
    } req_lat_t;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way grant picker: round-robin by default, fixed priority (port 0 wins)
// when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] pick
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_s;
    assign unused_last_s = last;

    // Port 0 always takes precedence.
    always_comb begin
        pick = 2'b00;
        if (req[0]) begin
            pick = 2'b01;
        end else if (req[1]) begin
            pick = 2'b10;
        end else begin
            pick = 2'b00;
        end
    end
`else
    // Under contention the port that was not granted last wins.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/ram8156_arbiter.sv
// Shares one strobe-driven ram8156 between two requesters and sequences the
// SETUP/STROBE/RECOVER bus cycle. Option macro: RAM_ARB_FIXED_PRIO_EN.
module ram8156_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [7:0]    addr0,
    input  logic [7:0]    addr1,
    input  logic [7:0]    wdata0,
    input  logic [7:0]    wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [7:0]    rdata,
    output logic          busy,
    output logic [7:0]    ram_addr,
    inout  wire  [7:0]    ram_data,
    output logic          ram_CSn,
    output logic          ram_WRn,
    output logic          ram_RDn,
    output logic          ram_IOMn
);

    arb_state_t      state_r;
    arb_state_t      state_s;
    logic [3:0]      cnt_r;
    req_lat_t        lat_r;
    req_lat_t        sel_s;
    logic [1:0]      pick_s;
    logic            last_r;
    logic            start_s;
    logic            leave_strobe_s;
    logic [1:0]      gnt_r;
    logic [1:0]      done_r;
    logic [7:0]      rdata_r;
    logic [7:0]      addr_r;
    logic            csn_r;
    logic            wrn_r;
    logic            rdn_r;
    logic            iomn_r;
    logic            drive_r;
    logic            busy_r;

    ram_arb_rr2 u_pick (
        .req  (req),
        .last (last_r),
        .pick (pick_s)
    );

    // Select the winning port's request fields for latching.
    always_comb begin
        sel_s = '0;
        if (pick_s[1]) begin
            sel_s = '{addr: addr1, wdata: wdata1, we: we[1]};
        end else begin
            sel_s = '{addr: addr0, wdata: wdata0, we: we[0]};
        end
    end

    // Next-state logic for the bus-cycle sequencer.
    always_comb begin
        state_s        = state_r;
        start_s        = 1'b0;
        leave_strobe_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    state_s = SETUP;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP:   state_s = STROBE;
            STROBE: begin
                if (cnt_r == 4'd0) begin
                    state_s        = RECOVER;
                    leave_strobe_s = 1'b1;
                end else begin
                    state_s = STROBE;
                end
            end
            RECOVER: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, request latch, grant and strobe-length counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            lat_r   <= '0;
            last_r  <= 1'b1;
            gnt_r   <= 2'b00;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                lat_r  <= sel_s;
                gnt_r  <= pick_s;
                last_r <= pick_s[1];
            end else if (state_r == RECOVER) begin
                gnt_r <= 2'b00;
            end
            if (state_r == SETUP) begin
                cnt_r <= 4'(WAIT_CYCLES - 1);
            end else if ((state_r == STROBE) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Bus pins follow the state being entered so they change exactly on the edge;
    // the async reset releases strobes and the data bus immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_r  <= 8'd0;
            csn_r   <= 1'b1;
            wrn_r   <= 1'b1;
            rdn_r   <= 1'b1;
            iomn_r  <= 1'b1;
            drive_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 2'b00;
            rdata_r <= 8'd0;
        end else begin
            if (start_s) begin
                addr_r <= sel_s.addr;
            end
            csn_r   <= !((state_s == SETUP) || (state_s == STROBE));
            iomn_r  <= !(state_s == STROBE);
            wrn_r   <= !((state_s == STROBE) && lat_r.we);
            rdn_r   <= !((state_s == STROBE) && !lat_r.we);
            drive_r <= start_s ? sel_s.we : ((state_s != IDLE) && lat_r.we);
            busy_r  <= (state_s != IDLE);
            done_r  <= leave_strobe_s ? gnt_r : 2'b00;
            if (leave_strobe_s && !lat_r.we) begin
                rdata_r <= ram_data;
            end
        end
    end

    assign ram_data = drive_r ? lat_r.wdata : {DW{1'bz}};
    assign gnt      = gnt_r;
    assign done     = done_r;
    assign rdata    = rdata_r;
    assign busy     = busy_r;
    assign ram_addr = addr_r;
    assign ram_CSn  = csn_r;
    assign ram_WRn  = wrn_r;
    assign ram_RDn  = rdn_r;
    assign ram_IOMn = iomn_r;

endmodule

// File: tb/tb_ram8156_arbiter.sv
// Randomized bench for ram8156_arbiter against a transaction-level model
// (expected memory image, grant order and cycle latency).
module tb_ram8156_arbiter;

    parameter int WC = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] gnt, done;
    logic [7:0] rdata, ram_addr;
    logic       busy, ram_CSn, ram_WRn, ram_RDn, ram_IOMn;
    wire  [7:0] ram_data;

    logic [7:0] dev_mem [256];
    logic [7:0] ref_mem [256];
    logic       pl_en;
    logic [7:0] pl_a, pl_v;

    int checks   = 0;
    int failures = 0;
    int last_gnt = 1;

    always #5 clk = ~clk;

    ram8156_arbiter #(.WAIT_CYCLES(WC)) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_CSn(ram_CSn), .ram_WRn(ram_WRn), .ram_RDn(ram_RDn), .ram_IOMn(ram_IOMn)
    );

    // Device model: drives on read strobe, captures on write strobe; pulled up when idle.
    assign ram_data = (!ram_CSn && !ram_RDn) ? dev_mem[ram_addr] : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (ram_data[i]);
    end

    always @(posedge clk) begin
        if (pl_en) dev_mem[pl_a] <= pl_v;
        else if (!ram_CSn && !ram_WRn) dev_mem[ram_addr] <= ram_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_model(input logic [1:0] m);
        if (m == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last_gnt;
`endif
        end
        return m[1] ? 1 : 0;
    endfunction

    // Issue one request set at a negedge with the DUT idle and follow every cycle to done.
    task automatic run_group(input logic [1:0] mask, input logic [1:0] wem,
                             input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input bit mutate, input bit pulse);
        logic [7:0] ea [2];
        logic [7:0] ed [2];
        logic [1:0] pend;
        logic [1:0] oh;
        int owner, n, exp_lat, rdc, wrc;
        bit first;
        ea[0] = a0; ea[1] = a1; ed[0] = d0; ed[1] = d1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; we = wem; req = mask;
        pend = mask;
        first = 1'b1;
        while (pend != 2'b00) begin
            owner    = pick_model(pend);
            last_gnt = owner;
            oh       = (owner == 1) ? 2'b10 : 2'b01;
            exp_lat  = first ? (2 + WC) : (3 + WC);
            n = 0; rdc = 0; wrc = 0;
            do begin
                @(posedge clk);
                n++;
                @(negedge clk);
                check_eq("strobe_excl", {31'd0, ram_WRn | ram_RDn}, 32'd1);
                if (!ram_WRn || !ram_RDn) begin
                    if (!ram_RDn) rdc++;
                    if (!ram_WRn) wrc++;
                    check_eq("strobe_addr", {24'd0, ram_addr}, {24'd0, ea[owner]});
                    check_eq("strobe_csn_iom", {30'd0, ram_CSn, ram_IOMn}, 32'd0);
                    if (wem[owner]) check_eq("strobe_wdata", {24'd0, ram_data}, {24'd0, ed[owner]});
                end
                if (mutate && n == 1) begin
                    addr1  = a1 ^ 8'h55;
                    wdata1 = ~d1;
                end
                if (pulse && n == 2) req[0] = 1'b1;
                if (pulse && n == 3) req[0] = 1'b0;
            end while (done == 2'b00 && n < exp_lat + 6);
            check_eq("done_latency", n, exp_lat);
            check_eq("done_port", {30'd0, done}, {30'd0, oh});
            check_eq("gnt_port", {30'd0, gnt}, {30'd0, oh});
            check_eq("busy_cycle", {31'd0, busy}, 32'd1);
            check_eq("rd_low_cycles", rdc, wem[owner] ? 0 : WC);
            check_eq("wr_low_cycles", wrc, wem[owner] ? WC : 0);
            if (wem[owner]) ref_mem[ea[owner]] = ed[owner];
            else check_eq("rdata", {24'd0, rdata}, {24'd0, ref_mem[ea[owner]]});
            req[owner]  = 1'b0;
            pend[owner] = 1'b0;
            first = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("idle_after", {29'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int n, bad;
        bit seen;
        logic [1:0] m;
        rstn = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = 8'd0; addr1 = 8'd0; wdata0 = 8'd0; wdata1 = 8'd0;
        pl_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pl_a = 8'(i);
            pl_v = (i == 255) ? 8'h5A : 8'($urandom);
            ref_mem[i] = pl_v;
            @(negedge clk);
        end
        pl_en = 1'b0;

        check_eq("rst_outs", {24'd0, gnt, done, busy, 3'd0}, 32'd0);
        check_eq("rst_rdata_addr", {16'd0, rdata, ram_addr}, 32'd0);
        check_eq("rst_strobes", {28'd0, ram_CSn, ram_WRn, ram_RDn, ram_IOMn}, 32'hF);
        check_eq("rst_bus_z", {24'd0, ram_data}, 32'hFF);
        rstn = 1'b1;
        @(negedge clk);

        // Reset asserted in the middle of a write strobe.
        addr0 = 8'h77; wdata0 = 8'h00; we = 2'b01; req = 2'b01;
        n = 0;
        while (ram_WRn && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_reach_strobe", {31'd0, ram_WRn}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        check_eq("rstmid_strobes", {28'd0, ram_CSn, ram_WRn, ram_RDn, ram_IOMn}, 32'hF);
        check_eq("rstmid_bus_z", {24'd0, ram_data}, 32'hFF);
        check_eq("rstmid_gnt_done", {27'd0, gnt, done, busy}, 32'd0);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        last_gnt = 1;
        seen = 1'b0;
        for (int i = 0; i < 2 * WC + 6; i++) begin
            @(negedge clk);
            if (done != 2'b00) seen = 1'b1;
        end
        check_eq("rstmid_no_done", {31'd0, seen}, 32'd0);

        // Write then read back through port 0.
        run_group(2'b01, 2'b01, 8'h3C, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);
        run_group(2'b01, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("readback_3c", {24'd0, rdata}, 32'hA5);
        // Port 1 read of the preloaded top address.
        run_group(2'b10, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("read_ff", {24'd0, rdata}, 32'h5A);
        // Contention: both ports write 0x10+port to distinct addresses.
        for (int k = 0; k < 2; k++)
            run_group(2'b11, 2'b11, 8'(8'h40 + 2 * k), 8'(8'h41 + 2 * k), 8'h10, 8'h11, 1'b0, 1'b0);
        // Inputs changed after grant, and a short port 0 pulse while busy.
        run_group(2'b10, 2'b10, 8'h00, 8'h20, 8'h00, 8'hC3, 1'b1, 1'b0);
        run_group(2'b10, 2'b00, 8'h00, 8'h21, 8'h00, 8'h00, 1'b0, 1'b1);

        for (int k = 0; k < 60; k++) begin
            m = 2'($urandom_range(1, 3));
            run_group(m, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom),
                      (m == 2'b10) && ($urandom_range(0, 1) == 1),
                      (m == 2'b10) && ($urandom_range(0, 1) == 1));
        end

        bad = 0;
        for (int i = 0; i < 256; i++)
            if (dev_mem[i] !== ref_mem[i]) bad++;
        check_eq("mem_image", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
